// File: rtl/axil_ram_arbiter_pkg.sv
// Shared types and helpers for the AXI-Lite RAM arbiter.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP
  } arb_state_t;

  localparam int AXIL_RESP_ERR_BIT = 1;

  function automatic logic [31:0] word_to_byte_addr(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/axil_ram_arbiter_if.sv
// AXI-Lite master port bundle between the arbiter and the RAM wrapper.
interface axil_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arprot, arvalid, rready,
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axil_ram_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after last_grant+1.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  int   cand;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= N) cand = cand - N;
      if (!found && |(req & (N'(1) << cand))) begin
        found     = 1'b1;
        grant     = N'(1) << cand;
        grant_idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axil_ram_arbiter.sv
// Serialises word-indexed requests from several kernels onto one AXI-Lite
// master port, one transaction at a time, with round-robin selection.
module axil_ram_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*32-1:0]         req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          resp_err,
  axil_ram_arbiter_if.master            m_axil
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t             state_q;
  arb_state_t             state_d;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       arb_idx;
  logic [NUM_REQ-1:0]     arb_grant;
  logic [31:0]            lat_addr;
  logic [DATA_WIDTH-1:0]  lat_wdata;
  logic                   aw_done;
  logic                   w_done;
  logic                   start;
  logic                   unused_resp_bits;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  // Grant is only offered from IDLE and never while reset is asserted.
  assign start     = (state_q == IDLE) && (|req_valid) && !rst;
  assign req_ready = start ? arb_grant : '0;

  assign m_axil.araddr  = ADDR_WIDTH'(word_to_byte_addr(lat_addr));
  assign m_axil.awaddr  = ADDR_WIDTH'(word_to_byte_addr(lat_addr));
  assign m_axil.arprot  = 3'b000;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.arvalid = (state_q == RD_ADDR);
  assign m_axil.rready  = (state_q == RD_DATA);
  assign m_axil.awvalid = (state_q == WR_ADDR) && !aw_done;
  assign m_axil.wvalid  = (state_q == WR_ADDR) && !w_done;
  assign m_axil.wdata   = lat_wdata;
  assign m_axil.wstrb   = '1;
  assign m_axil.bready  = (state_q == WR_RESP);

  assign unused_resp_bits = ^{m_axil.rresp[0], m_axil.bresp[0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = req_write[arb_idx] ? WR_ADDR : RD_ADDR;
      RD_ADDR: if (m_axil.arready) state_d = RD_DATA;
      RD_DATA: if (m_axil.rvalid) state_d = IDLE;
      WR_ADDR: if ((aw_done || m_axil.awready) && (w_done || m_axil.wready)) state_d = WR_RESP;
      WR_RESP: if (m_axil.bvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_valid <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            last_grant <= arb_idx;
            owner      <= arb_idx;
            lat_addr   <= 32'(req_addr >> (32 * int'(arb_idx)));
            lat_wdata  <= DATA_WIDTH'(req_wdata >> (DATA_WIDTH * int'(arb_idx)));
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
          end
        end
        RD_DATA: begin
          if (m_axil.rvalid) begin
            resp_rdata <= m_axil.rdata;
            resp_err   <= m_axil.rresp[AXIL_RESP_ERR_BIT];
            resp_valid <= NUM_REQ'(1) << owner;
          end
        end
        // AW and W complete independently; each valid drops once its flag sets.
        WR_ADDR: begin
          if (m_axil.awready) aw_done <= 1'b1;
          if (m_axil.wready)  w_done  <= 1'b1;
        end
        WR_RESP: begin
          if (m_axil.bvalid) begin
            resp_err   <= m_axil.bresp[AXIL_RESP_ERR_BIT];
            resp_valid <= NUM_REQ'(1) << owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_ram_arbiter.sv
// Directed and randomized bench for axil_ram_arbiter with a RAM slave model.
module tb_axil_ram_arbiter;

  localparam int NR   = 2;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int NOPS = 20;

  typedef struct {
    logic        wr;
    logic [31:0] idx;
    logic [31:0] data;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_write;
  logic [NR*32-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    resp_valid;
  logic [DW-1:0]    resp_rdata;
  logic             resp_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic man_mode = 1'b0, man_arready = 1'b0, man_awready = 1'b0, man_wready = 1'b0;
  logic err_inject = 1'b0;
  logic poke_en = 1'b0;
  logic [13:0] poke_idx = '0;
  logic [31:0] poke_data = '0;

  bit [31:0] smem [0:16383];
  bit [31:0] ref_mem [int];
  op_t       q [NR][$];

  logic          aw_got, w_got, aw_fire, w_fire;
  logic [AW-1:0] aw_l, cur_aw;
  logic [DW-1:0] wd_l, cur_wd;

  axil_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axil ();

  axil_ram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .m_axil     (axil)
  );

  always #5 clk = ~clk;

  // RAM slave: zero-wait readies unless the bench takes manual control.
  assign axil.arready = man_mode ? man_arready : 1'b1;
  assign axil.awready = man_mode ? man_awready : 1'b1;
  assign axil.wready  = man_mode ? man_wready  : 1'b1;
  assign axil.bresp   = 2'b00;
  assign aw_fire = axil.awvalid && axil.awready;
  assign w_fire  = axil.wvalid && axil.wready;
  assign cur_aw  = aw_got ? aw_l : axil.awaddr;
  assign cur_wd  = w_got ? wd_l : axil.wdata;

  always @(posedge clk) begin
    if (poke_en) smem[poke_idx] <= poke_data;
    if (rst) begin
      axil.rvalid <= 1'b0;
      axil.rdata  <= '0;
      axil.rresp  <= 2'b00;
      axil.bvalid <= 1'b0;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      aw_l        <= '0;
      wd_l        <= '0;
    end else begin
      if (axil.rvalid && axil.rready) axil.rvalid <= 1'b0;
      if (axil.arvalid && axil.arready) begin
        axil.rvalid <= 1'b1;
        axil.rdata  <= smem[axil.araddr[AW-1:2]];
        axil.rresp  <= err_inject ? 2'b10 : 2'b00;
      end
      if (axil.bvalid && axil.bready) axil.bvalid <= 1'b0;
      if ((aw_got || aw_fire) && (w_got || w_fire)) begin
        smem[cur_aw[AW-1:2]] <= cur_wd;
        axil.bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_fire) begin aw_got <= 1'b1; aw_l <= axil.awaddr; end
        if (w_fire)  begin w_got  <= 1'b1; wd_l <= axil.wdata;  end
      end
    end
  end

  function automatic logic [NR-1:0] oh(input int r);
    return NR'(1) << r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    poke_en = 1'b1; poke_idx = 14'(idx); poke_data = data;
    ref_mem[idx] = data;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; man_mode = 1'b0; err_inject = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_arvalid"}, 64'(axil.arvalid), 64'(0));
    chk({tag, "_awvalid"}, 64'(axil.awvalid), 64'(0));
    chk({tag, "_wvalid"},  64'(axil.wvalid),  64'(0));
    chk({tag, "_rready"},  64'(axil.rready),  64'(0));
    chk({tag, "_bready"},  64'(axil.bready),  64'(0));
    chk({tag, "_araddr"},  64'(axil.araddr),  64'(0));
    chk({tag, "_awaddr"},  64'(axil.awaddr),  64'(0));
    chk({tag, "_wdata"},   64'(axil.wdata),   64'(0));
    chk({tag, "_respv"},   64'(resp_valid),   64'(0));
    chk({tag, "_rdata"},   64'(resp_rdata),   64'(0));
    chk({tag, "_err"},     64'(resp_err),     64'(0));
  endtask

  // Raises one request in cycle 0, checks the accept, leaves at cycle 1.
  task automatic issue(input int r, input logic wr, input logic [31:0] idx,
                       input logic [31:0] data, input string tag);
    req_valid[r] = 1'b1;
    req_write[r] = wr;
    req_addr[r*32 +: 32] = idx;
    req_wdata[r*DW +: DW] = data;
    #1;
    chk(tag, 64'(req_ready), 64'(oh(r)));
    tick();
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_resp(input int cyc0, input int r, input int exp_lat, input logic chk_data,
                           input logic [31:0] exp_data, input logic exp_err, input string tag);
    int cyc;
    cyc = cyc0;
    while (resp_valid == '0 && cyc < cyc0 + 60) begin
      tick();
      cyc++;
    end
    chk({tag, "_owner"},   64'(resp_valid), 64'(oh(r)));
    chk({tag, "_latency"}, 64'(cyc),        64'(exp_lat));
    if (chk_data) chk({tag, "_rdata"}, 64'(resp_rdata), 64'(exp_data));
    chk({tag, "_err"}, 64'(resp_err), 64'(exp_err));
  endtask

  function automatic bit work_left();
    for (int r = 0; r < NR; r++) if (q[r].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [NR-1:0] exp_rv, exp_g, act;
    int   m_last, g, c, wait_cnt, cyc, n_served, key, exp_owner;
    logic busy, exp_rd;
    logic [31:0] exp_data;
    op_t  op;

    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    poke(5, 32'hDEADBEEF);

    // Reset: no accept while rst is high, all outputs at reset values after.
    tick();
    req_valid = 2'b01;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    req_valid = '0;
    tick();
    rst = 1'b0;
    chk_idle("rst");
    chk("rst_wstrb", 64'(axil.wstrb), 64'(4'hF));
    chk("rst_prot",  64'({axil.arprot, axil.awprot}), 64'(0));

    // Single zero-wait read.
    issue(0, 1'b0, 32'd5, 32'd0, "rd_accept");
    chk("rd_arvalid", 64'(axil.arvalid), 64'(1));
    chk("rd_araddr",  64'(axil.araddr),  64'(16'h0014));
    tick();
    chk("rd_rready", 64'(axil.rready), 64'(1));
    wait_resp(2, 0, 3, 1'b1, 32'hDEADBEEF, 1'b0, "rd");

    // Write then read-back from requester 1.
    issue(1, 1'b1, 32'd3, 32'h12345678, "wr_accept");
    ref_mem[3] = 32'h12345678;
    chk("wr_awvalid", 64'(axil.awvalid), 64'(1));
    chk("wr_wvalid",  64'(axil.wvalid),  64'(1));
    chk("wr_awaddr",  64'(axil.awaddr),  64'(16'h000C));
    chk("wr_wdata",   64'(axil.wdata),   64'(32'h12345678));
    chk("wr_wstrb",   64'(axil.wstrb),   64'(4'hF));
    tick();
    chk("wr_bready", 64'(axil.bready), 64'(1));
    chk("wr_bvalid", 64'(axil.bvalid), 64'(1));
    wait_resp(2, 1, 3, 1'b0, 32'd0, 1'b0, "wr");
    issue(1, 1'b0, 32'd3, 32'd0, "rb_accept");
    wait_resp(1, 1, 3, 1'b1, 32'h12345678, 1'b0, "rb");

    // Contention: both hold reads; grants alternate, 3 cycles each.
    do_reset();
    req_write = '0;
    req_addr  = {32'd3, 32'd5};
    req_valid = 2'b11;
    for (int k = 0; k <= 12; k++) begin
      #1;
      exp_g  = (k % 3 == 0) ? oh((k / 3) % 2) : '0;
      exp_rv = (k >= 3 && k % 3 == 0) ? oh(((k / 3) - 1) % 2) : '0;
      chk($sformatf("ct_grant_c%0d", k), 64'(req_ready), 64'(exp_g));
      chk($sformatf("ct_resp_c%0d", k),  64'(resp_valid), 64'(exp_rv));
      if (exp_rv != '0)
        chk($sformatf("ct_rdata_c%0d", k), 64'(resp_rdata),
            64'((((k / 3) - 1) % 2 == 0) ? 32'hDEADBEEF : 32'h12345678));
      @(posedge clk);
    end
    #1;
    req_valid = '0;

    // Split AW/W handshake.
    do_reset();
    man_mode = 1'b1; man_awready = 1'b0; man_wready = 1'b0; man_arready = 1'b0;
    issue(0, 1'b1, 32'd7, 32'hA5A5A5A5, "sp_accept");
    ref_mem[7] = 32'hA5A5A5A5;
    man_awready = 1'b1;
    chk("sp_c1_awvalid", 64'(axil.awvalid), 64'(1));
    chk("sp_c1_wvalid",  64'(axil.wvalid),  64'(1));
    tick();
    man_awready = 1'b0;
    chk("sp_c2_awvalid", 64'(axil.awvalid), 64'(0));
    chk("sp_c2_wvalid",  64'(axil.wvalid),  64'(1));
    tick();
    chk("sp_c3_wvalid", 64'(axil.wvalid), 64'(1));
    tick();
    man_wready = 1'b1;
    chk("sp_c4_wvalid", 64'(axil.wvalid), 64'(1));
    chk("sp_c4_bready", 64'(axil.bready), 64'(0));
    tick();
    man_wready = 1'b0;
    chk("sp_c5_wvalid", 64'(axil.wvalid), 64'(0));
    chk("sp_c5_bready", 64'(axil.bready), 64'(1));
    wait_resp(5, 0, 6, 1'b0, 32'd0, 1'b0, "sp");

    // Stalled AR, then reset mid-transaction.
    do_reset();
    man_mode = 1'b1; man_arready = 1'b0;
    issue(1, 1'b0, 32'd3, 32'd0, "st_accept");
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("st_arvalid_c%0d", k), 64'(axil.arvalid), 64'(1));
      chk($sformatf("st_respv_c%0d", k),   64'(resp_valid),   64'(0));
      tick();
    end
    rst = 1'b1;
    tick();
    chk_idle("st_rst");
    req_write = '0;
    req_addr  = {32'd3, 32'd5};
    req_valid = 2'b11;
    #1;
    chk("st_rst_req_ready", 64'(req_ready), 64'(0));
    tick();
    rst = 1'b0;
    man_mode = 1'b0;
    #1;
    chk("st_first_grant", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = '0;
    wait_resp(1, 0, 3, 1'b1, 32'hDEADBEEF, 1'b0, "st");

    // Error response on read.
    do_reset();
    err_inject = 1'b1;
    issue(0, 1'b0, 32'h0000_4005, 32'd0, "er_accept");
    chk("er_araddr_wrap", 64'(axil.araddr), 64'(16'h0014));
    wait_resp(1, 0, 3, 1'b1, 32'hDEADBEEF, 1'b1, "er");
    err_inject = 1'b0;

    // Randomized traffic with random slave stalls against the reference model.
    do_reset();
    man_mode = 1'b1;
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < NOPS; k++) begin
        op.wr   = 1'($urandom_range(0, 1));
        op.idx  = 32'($urandom_range(0, 15)) | (32'($urandom_range(0, 3)) << 14);
        op.data = $urandom;
        q[r].push_back(op);
      end
    act = '0; busy = 1'b0; m_last = NR - 1; n_served = 0; cyc = 0;
    wait_cnt = 0; exp_owner = 0; exp_rd = 1'b0; exp_data = '0;
    while (cyc < 6000 && (busy || work_left() || act != '0)) begin
      tick();
      cyc++;
      if (busy) begin
        if (resp_valid != '0) begin
          chk("rnd_owner", 64'(resp_valid), 64'(oh(exp_owner)));
          if (exp_rd) chk("rnd_rdata", 64'(resp_rdata), 64'(exp_data));
          chk("rnd_err", 64'(resp_err), 64'(0));
          busy = 1'b0;
          n_served++;
        end else if (++wait_cnt > 60) begin
          chk("rnd_timeout", 64'(resp_valid), 64'(oh(exp_owner)));
          busy = 1'b0;
        end
      end else if (resp_valid != '0) begin
        chk("rnd_spurious", 64'(resp_valid), 64'(0));
      end
      for (int r = 0; r < NR; r++) begin
        if (!act[r] && q[r].size() > 0 && $urandom_range(0, 2) != 0) begin
          act[r] = 1'b1;
          req_write[r] = q[r][0].wr;
          req_addr[r*32 +: 32] = q[r][0].idx;
          req_wdata[r*DW +: DW] = q[r][0].data;
        end
      end
      req_valid   = act;
      man_arready = 1'($urandom_range(0, 1));
      man_awready = 1'($urandom_range(0, 1));
      man_wready  = 1'($urandom_range(0, 1));
      #1;
      g = -1;
      if (!busy)
        for (int k = 1; k <= NR; k++) begin
          c = (m_last + k) % NR;
          if (g < 0 && req_valid[c]) g = c;
        end
      exp_g = (g >= 0) ? oh(g) : '0;
      chk("rnd_grant", 64'(req_ready), 64'(exp_g));
      if (g >= 0) begin
        m_last = g;
        busy = 1'b1;
        wait_cnt = 0;
        exp_owner = g;
        op = q[g].pop_front();
        act[g] = 1'b0;
        key = int'(op.idx & 32'h3FFF);
        if (op.wr) begin
          ref_mem[key] = op.data;
          exp_rd = 1'b0;
        end else begin
          exp_rd = 1'b1;
          exp_data = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
        end
      end
    end
    req_valid = '0;
    chk("rnd_served", 64'(n_served), 64'(NR * NOPS));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
